// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential N-bit ALU.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_SHR = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/adder_nbit.sv
// Ripple-style WIDTH-bit adder with carry in/out, shared by ADD, SUB and the MUL accumulate.
module adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/alu_nbit_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshake; MUL is a WIDTH-cycle shift-add.
module alu_nbit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         opcode,
    input  logic [A_WIDTH-1:0] a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               zflag,
    output logic               c,
    output logic               nflag
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 z_q, z_d, c_q, c_d, n_q, n_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]     ext_a;
    logic [SH_W-1:0]      sh;
    logic                 accept;
    logic [WIDTH-1:0]     add_a, add_b, add_s;
    logic                 add_cin, add_cout;
    logic [WIDTH:0]       shl_full, shr_full;
    logic [2*WIDTH-1:0]   prod_step;
    logic [WIDTH-1:0]     res;
    logic                 res_c, load;
    logic                 prod_unused;

    always_comb begin
        ext_a = '0;
        ext_a[A_WIDTH-1:0] = a;
    end

    assign sh       = ext_a[SH_W-1:0];
    assign in_ready = rst_n && (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;

    // The extra bit on each shift captures the last bit shifted out (zero when sh==0).
    assign shl_full = {1'b0, b} << sh;
    assign shr_full = {b, 1'b0} >> sh;

    // One shift-add step: add multiplicand into the high half, shift the whole product right.
    assign prod_step   = {add_cout, add_s, prod_q[WIDTH-1:1]};
    assign prod_unused = prod_q[0];

    always_comb begin
        if (state_q == S_EXEC) begin
            add_a   = prod_q[2*WIDTH-1:WIDTH];
            add_b   = mplier_q[0] ? mcand_q : '0;
            add_cin = 1'b0;
        end else begin
            add_a   = b;
            add_b   = (opcode == ALU_SUB) ? ~ext_a : ext_a;
            add_cin = (opcode == ALU_SUB);
        end
    end

    adder_nbit #(.WIDTH(WIDTH)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout)
    );

    always_comb begin
        state_d  = state_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        res      = '0;
        res_c    = 1'b0;
        load     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (opcode == ALU_MUL) begin
                        state_d  = S_EXEC;
                        prod_d   = '0;
                        mplier_d = ext_a;
                        mcand_d  = b;
                        cnt_d    = '0;
                    end else begin
                        state_d = S_DONE;
                        load    = 1'b1;
                        case (opcode)
                            ALU_ADD: begin res = add_s; res_c = add_cout;  end
                            ALU_SUB: begin res = add_s; res_c = ~add_cout; end
                            ALU_AND: res = b & ext_a;
                            ALU_OR:  res = b | ext_a;
                            ALU_XOR: res = b ^ ext_a;
                            ALU_SHL: begin res = shl_full[WIDTH-1:0]; res_c = shl_full[WIDTH]; end
                            ALU_SHR: begin res = shr_full[WIDTH:1];   res_c = shr_full[0];     end
                            default: res = '0;
                        endcase
                    end
                end
            end
            S_EXEC: begin
                prod_d   = prod_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Last iteration writes the finished product straight into the result registers.
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    load    = 1'b1;
                    res     = prod_step[WIDTH-1:0];
                    res_c   = |prod_step[2*WIDTH-1:WIDTH];
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        data_d = data_q;
        z_d    = z_q;
        c_d    = c_q;
        n_d    = n_q;
        if (load) begin
            data_d = res;
            z_d    = (res == '0);
            c_d    = res_c;
            n_d    = res[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            prod_q   <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            z_q      <= z_d;
            c_q      <= c_d;
            n_q      <= n_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign data_out  = data_q;
    assign zflag     = z_q;
    assign c         = c_q;
    assign nflag     = n_q;

endmodule
